// File: rtl/icache_refill_responder.sv
// icache_refill_responder
//   TileLink-UL responder at the memory side of the icache refill path.
//   A Get on channel A becomes a burst of 1..BEATS reads on a synchronous
//   memory port (1-cycle latency). The read data goes through a 2-entry beat
//   buffer and comes back as AccessAckData beats on channel D.
//   An oversized Get is answered with denied+corrupt beats and does no reads.
//   A non-Get opcode is answered with one denied AccessAck beat.
//
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   a_valid/a_ready           A request handshake; a_ready is high only in IDLE
//   a_opcode/size/source/address  request fields (Get = 4)
//   d_valid/d_ready           D response handshake
//   d_opcode/size/source/data/denied/corrupt  response beat fields
//   mem_req/mem_addr          beat-aligned read strobe and address
//   mem_rdata/mem_err         read data and error, one cycle after mem_req
//
// Optional build macro ICACHE_REFILL_RESP_ERR_INJECT_EN
//   Adds input err_inject, which is ORed into the corrupt bit of each read
//   beat. Also adds output inj_cnt, a saturating count of injected beats that
//   completed a D handshake.
//
// BEATS and DATA_W/8 must be powers of two.
module icache_refill_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 8,
  parameter int SRC_W  = 1,
  parameter int SIZE_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [SIZE_W-1:0] a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [SIZE_W-1:0] d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic [DATA_W-1:0] d_data,
  output logic              d_denied,
  output logic              d_corrupt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
  ,
  input  logic              err_inject,
  output logic [7:0]        inj_cnt
`endif
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LB     = $clog2(BYTES);
  localparam int LBEATS = $clog2(BEATS);
  localparam int CNT_W  = LBEATS + 1;

  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                a_ready_q, a_ready_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [SRC_W-1:0]    source_q, source_d;
  logic                denied_q, denied_d;
  logic                over_q, over_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    nbeats_q, nbeats_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   buf_data_q [2];
  logic [DATA_W-1:0]   buf_data_d [2];
  logic                buf_corr_q [2];
  logic                buf_corr_d [2];
`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
  logic                buf_inj_q [2];
  logic                buf_inj_d [2];
  logic [7:0]          inj_cnt_q, inj_cnt_d;
`endif

  logic                accept_s, pop_s, issue_s, gen_s, push_s;
  logic [2:0]          occ_s;
  logic                is_get_s, req_over_s;
  logic [CNT_W-1:0]    req_nbeats_s;
  logic [ADDR_W-1:0]   req_mask_s;
  logic [DATA_W-1:0]   push_data_s;
  logic                push_corr_s;
  logic                push_inj_s;

  // Request decode: beat count, oversize detection and the alignment mask.
  always_comb begin
    is_get_s   = (a_opcode == OP_GET);
    req_over_s = is_get_s && (int'(a_size) > LB + LBEATS);
    if (!is_get_s || (int'(a_size) <= LB)) begin
      req_nbeats_s = CNT_W'(1);
    end else if (req_over_s) begin
      // Counters only span BEATS, so a denied oversized burst is BEATS long.
      req_nbeats_s = CNT_W'(BEATS);
    end else begin
      req_nbeats_s = CNT_W'(1) << (int'(a_size) - LB);
    end
    // Align to the transfer size and never finer than one beat.
    req_mask_s = ((ADDR_W'(1) << a_size) - ADDR_W'(1)) | ADDR_W'(BYTES - 1);
  end

  // Handshake, issue and push decisions, plus the buffer write data.
  always_comb begin
    accept_s = a_valid && a_ready_q && (state_q == IDLE);
    pop_s    = (cnt_q != 2'd0) && d_ready;
    // Occupancy seen by the issue rule: held beats, plus the read in flight,
    // minus the beat leaving this cycle.
    occ_s    = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop_s};
    issue_s  = (state_q == BURST) && (occ_s < 3'd2);
    gen_s    = (state_q == DRAIN) && denied_q && (rd_cnt_q != nbeats_q) && (occ_s < 3'd2);
    push_s   = rd_pend_q || gen_s;
    if (rd_pend_q) begin
      push_data_s = mem_rdata;
`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
      push_corr_s = mem_err | err_inject;
      push_inj_s  = err_inject;
`else
      push_corr_s = mem_err;
      push_inj_s  = 1'b0;
`endif
    end else begin
      push_data_s = {DATA_W{1'b0}};
      push_corr_s = over_q;
      push_inj_s  = 1'b0;
    end
  end

  // Next-state logic for the FSM, the counters and the beat buffer.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    size_d     = size_q;
    source_d   = source_q;
    denied_d   = denied_q;
    over_d     = over_q;
    base_d     = base_q;
    nbeats_d   = nbeats_q;
    rd_cnt_d   = rd_cnt_q;
    tx_cnt_d   = pop_s ? (tx_cnt_q + CNT_W'(1)) : tx_cnt_q;
    rd_pend_d  = issue_s;
    buf_data_d = buf_data_q;
    buf_corr_d = buf_corr_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          opcode_d = is_get_s ? OP_ACK_DATA : OP_ACK;
          size_d   = a_size;
          source_d = a_source;
          denied_d = !is_get_s || req_over_s;
          over_d   = req_over_s;
          base_d   = a_address & ~req_mask_s;
          nbeats_d = req_nbeats_s;
          rd_cnt_d = {CNT_W{1'b0}};
          tx_cnt_d = {CNT_W{1'b0}};
          state_d  = (is_get_s && !req_over_s) ? BURST : DRAIN;
        end else begin
          state_d  = IDLE;
        end
      end
      BURST: begin
        if (issue_s) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          state_d  = (rd_cnt_q == nbeats_q - CNT_W'(1)) ? DRAIN : BURST;
        end else begin
          state_d  = BURST;
        end
      end
      DRAIN: begin
        // For denied bursts rd_cnt counts the synthesised beats.
        if (gen_s) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
        if (pop_s && (tx_cnt_q == nbeats_q - CNT_W'(1))) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push_s) begin
      buf_data_d[wr_ptr_q] = push_data_s;
      buf_corr_d[wr_ptr_q] = push_corr_s;
    end else begin
      buf_data_d = buf_data_q;
    end
    wr_ptr_d  = wr_ptr_q ^ push_s;
    rd_ptr_d  = rd_ptr_q ^ pop_s;
    cnt_d     = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
    a_ready_d = (state_d == IDLE);
  end

`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
  // Injection tag per buffer slot and the saturating injected-beat counter.
  always_comb begin
    buf_inj_d = buf_inj_q;
    if (push_s) begin
      buf_inj_d[wr_ptr_q] = push_inj_s;
    end else begin
      buf_inj_d = buf_inj_q;
    end
    if (pop_s && buf_inj_q[rd_ptr_q] && (inj_cnt_q != 8'hFF)) begin
      inj_cnt_d = inj_cnt_q + 8'd1;
    end else begin
      inj_cnt_d = inj_cnt_q;
    end
  end
`endif

  // State and datapath registers; reset abandons any burst in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      a_ready_q     <= 1'b0;
      opcode_q      <= 3'd0;
      size_q        <= {SIZE_W{1'b0}};
      source_q      <= {SRC_W{1'b0}};
      denied_q      <= 1'b0;
      over_q        <= 1'b0;
      base_q        <= {ADDR_W{1'b0}};
      nbeats_q      <= {CNT_W{1'b0}};
      rd_cnt_q      <= {CNT_W{1'b0}};
      tx_cnt_q      <= {CNT_W{1'b0}};
      rd_pend_q     <= 1'b0;
      cnt_q         <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      buf_data_q[0] <= {DATA_W{1'b0}};
      buf_data_q[1] <= {DATA_W{1'b0}};
      buf_corr_q[0] <= 1'b0;
      buf_corr_q[1] <= 1'b0;
`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
      buf_inj_q[0]  <= 1'b0;
      buf_inj_q[1]  <= 1'b0;
      inj_cnt_q     <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      a_ready_q     <= a_ready_d;
      opcode_q      <= opcode_d;
      size_q        <= size_d;
      source_q      <= source_d;
      denied_q      <= denied_d;
      over_q        <= over_d;
      base_q        <= base_d;
      nbeats_q      <= nbeats_d;
      rd_cnt_q      <= rd_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      rd_pend_q     <= rd_pend_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      buf_data_q    <= buf_data_d;
      buf_corr_q    <= buf_corr_d;
`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
      buf_inj_q     <= buf_inj_d;
      inj_cnt_q     <= inj_cnt_d;
`endif
    end
  end

  assign a_ready   = a_ready_q;
  assign d_valid   = (cnt_q != 2'd0);
  assign d_opcode  = opcode_q;
  assign d_size    = size_q;
  assign d_source  = source_q;
  assign d_denied  = denied_q;
  assign d_data    = buf_data_q[rd_ptr_q];
  assign d_corrupt = buf_corr_q[rd_ptr_q];
  assign mem_req   = issue_s;
  // The start address is aligned to the burst window, so adding the beat
  // offset never carries out of it.
  assign mem_addr  = base_q + (ADDR_W'(rd_cnt_q) << LB);
`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
  assign inj_cnt   = inj_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill_responder.sv
// Testbench for icache_refill_responder: directed and random Get/non-Get
// requests. Expected beats come from a transaction-level model of the
// refill rules.
module tb_icache_refill_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = 3'd0;
  logic [2:0]  a_size = 3'd0;
  logic        a_source = 1'b0;
  logic [31:0] a_address = 32'd0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic        d_source;
  logic [31:0] d_data;
  logic        d_denied;
  logic        d_corrupt;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_err = 1'b0;
`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
  logic        err_inject = 1'b0;
  logic [7:0]  inj_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [40:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  icache_refill_responder dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_err(mem_err)
`ifdef ICACHE_REFILL_RESP_ERR_INJECT_EN
    , .err_inject(err_inject), .inj_cnt(inj_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  // Synchronous backing store: data and error one cycle after the strobe.
  always @(posedge clock) begin
    mem_rdata <= mem_word(mem_addr);
    mem_err   <= mem_req && (mem_addr == err_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // One request: rmode 0 = d_ready high, 1 = toggling, 2 = random.
  // rst_after >= 0 pulses reset once that many beats have been accepted.
  task automatic run_req(input logic [2:0] op, input logic [2:0] sz, input logic src,
                         input logic [31:0] addr, input int rmode, input int rst_after);
    int          bytes, nb, n_reads, reads, got, outst, first_v, first_hs, last_hs, hs_cyc, waitc;
    logic        is_get, over;
    logic [31:0] start, ak;
    logic [40:0] cur, prev;
    logic        prev_stall;
    is_get  = (op == 3'd4);
    bytes   = 1 << sz;
    over    = is_get && (bytes > 32);
    nb      = !is_get ? 1 : (over ? 8 : ((bytes <= 4) ? 1 : bytes / 4));
    start   = addr & ~(32'(bytes) - 32'd1) & ~32'd3;
    n_reads = (is_get && !over) ? nb : 0;
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < nb; k++) begin
      ak = start + 32'(4 * k);
      if (is_get && !over) exp_addr_q.push_back(ak);
      exp_q.push_back({(is_get ? 3'd1 : 3'd0), (!is_get || over),
                       (over || (is_get && (ak == err_addr))), sz, src,
                       ((is_get && !over) ? mem_word(ak) : 32'd0)});
    end
    reads = 0; got = 0; outst = 0; first_v = -1; first_hs = -1; last_hs = -1;
    waitc = 0;
    while (!a_ready && waitc < 20) begin
      step();
      waitc++;
    end
    chk("a_ready_idle", a_ready, 1);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    step();
    hs_cyc = cyc;
    a_valid = 1'b0;
    prev_stall = 1'b0;
    prev = '0;
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) begin
      case (rmode)
        0:       d_ready = 1'b1;
        1:       d_ready = (t % 2 == 0);
        default: d_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_after >= 0 && got == rst_after) begin
        reset_n = 1'b0;
        #1;
        chk("rst_d_valid", d_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_d_fields", {d_opcode, d_denied, d_corrupt, d_size, d_source, d_data}, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_a_ready", a_ready, 1);
        for (int j = 0; j < 3; j++) begin
          chk("post_rst_d_valid", d_valid, 0);
          chk("post_rst_mem_req", mem_req, 0);
          step();
        end
        exp_q.delete();
        exp_addr_q.delete();
        return;
      end
      #1;
      cur = {d_opcode, d_denied, d_corrupt, d_size, d_source, d_data};
      if (prev_stall) chk("d_stable", cur, prev);
      if (mem_req) begin
        reads++;
        outst++;
        if (exp_addr_q.size() == 0) chk("mem_req_extra", reads, n_reads);
        else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (d_valid && first_v < 0) first_v = cyc;
      if (d_valid && d_ready) begin
        chk("beat", cur, exp_q.pop_front());
        got++;
        if (is_get && !over) outst--;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_q.size() == 0) chk("no_same_cycle_accept", a_ready, 0);
      end
      chk("read_ahead_le2", (outst <= 2), 1);
      prev_stall = d_valid && !d_ready;
      prev = cur;
      step();
    end
    chk("burst_done", exp_q.size(), 0);
    chk("read_count", reads, n_reads);
    chk("a_ready_after", a_ready, 1);
    chk("no_extra_beat", d_valid, 0);
    if (is_get && !over) chk("first_dvalid_lat", first_v - hs_cyc, 2);
    if (rmode == 0 && is_get && !over) chk("consecutive", last_hs - first_hs, nb - 1);
    d_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]  op, sz;
    logic [31:0] addr;
    #1;
    chk("reset_a_ready", a_ready, 0);
    chk("reset_d_valid", d_valid, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_d_fields", {d_opcode, d_denied, d_corrupt, d_size, d_source, d_data}, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("a_ready_after_reset", a_ready, 1);

    run_req(3'd4, 3'd5, 1'b0, 32'h0000_1004, 0, -1);
    run_req(3'd4, 3'd2, 1'b1, 32'h0000_2000, 0, -1);
    run_req(3'd4, 3'd5, 1'b1, 32'h0000_3040, 1, -1);
    run_req(3'd4, 3'd6, 1'b0, 32'h0000_4000, 0, -1);
    run_req(3'd0, 3'd2, 1'b1, 32'h0000_5000, 0, -1);
    err_addr = 32'h0000_600C;
    run_req(3'd4, 3'd5, 1'b0, 32'h0000_6000, 0, -1);
    err_addr = 32'hFFFF_FFFF;
    run_req(3'd4, 3'd5, 1'b0, 32'h0000_7000, 0, 4);
    run_req(3'd4, 3'd5, 1'b1, 32'h0000_7100, 0, -1);

    for (int i = 0; i < 10; i++) begin
      op       = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
      sz       = 3'($urandom_range(0, 7));
      addr     = $urandom;
      err_addr = (addr & ~32'h1F) + 32'(4 * $urandom_range(0, 7));
      run_req(op, sz, 1'($urandom_range(0, 1)), addr, 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
